// File: rtl/traffic_phase_scheduler.sv
// Two-road traffic phase scheduler with pedestrian walk
// and emergency preemption; Moore lamp decode.
module traffic_phase_scheduler #(
   parameter int CLK_DIV = 4,
   parameter int G_TIME  = 8,
   parameter int Y_TIME  = 3,
   parameter int AR_TIME = 2,
   parameter int W_TIME  = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       emergency,
   input  logic       emerg_dir,
   input  logic       ped_req,
   output logic       R1,
   output logic       Y1,
   output logic       G1,
   output logic       R2,
   output logic       Y2,
   output logic       G2,
   output logic       walk,
   output logic       ped_pending,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      GR1  = 3'd0,
      YL1  = 3'd1,
      AR1  = 3'd2,
      GR2  = 3'd3,
      YL2  = 3'd4,
      AR2  = 3'd5,
      WALK = 3'd6,
      EMG  = 3'd7
   } state_t;

   localparam int T1   = G_TIME > Y_TIME ? G_TIME : Y_TIME;
   localparam int T2   = AR_TIME > W_TIME ? AR_TIME : W_TIME;
   localparam int TMAX = T1 > T2 ? T1 : T2;
   localparam int TW   = TMAX > 1 ? $clog2(TMAX) : 1;
   localparam int PW   = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

   localparam logic [PW-1:0] PLAST = PW'(CLK_DIV - 1);

   state_t        state;
   state_t        state_n;
   logic [PW-1:0] presc;
   logic [TW-1:0] timer;
   logic          next_dir;
   logic          emerg_dir_q;
   logic          tick;
   logic          expire;
   logic          change;
   logic          walk_entry;

   assign tick       = presc == PLAST;
   assign expire     = tick && timer == '0;
   assign change     = state_n != state;
   assign walk_entry = change && state_n == WALK;
   assign phase      = state;

   function automatic logic [TW-1:0] load(input state_t s);
      case (s)
         GR1, GR2: return TW'(G_TIME - 1);
         YL1, YL2: return TW'(Y_TIME - 1);
         AR1, AR2: return TW'(AR_TIME - 1);
         WALK:     return TW'(W_TIME - 1);
         default:  return '0;
      endcase
   endfunction

   // Next-state: greens yield early to emergency, others run out
   always_comb begin
      state_n = state;
      unique case (state)
         GR1: if (emergency || expire) state_n = YL1;
         YL1: if (expire) state_n = AR1;
         AR1:
            if (expire)
               state_n = emergency   ? EMG :
                         ped_pending ? WALK : GR2;
         GR2: if (emergency || expire) state_n = YL2;
         YL2: if (expire) state_n = AR2;
         AR2:
            if (expire)
               state_n = emergency   ? EMG :
                         ped_pending ? WALK : GR1;
         WALK:
            if (expire)
               state_n = emergency ? EMG :
                         next_dir  ? GR2 : GR1;
         EMG:
            if (!emergency)
               state_n = emerg_dir_q ? YL2 : YL1;
      endcase
   end

   // State, prescaler and phase timer; all reload on any change
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= GR1;
         presc <= '0;
         timer <= TW'(G_TIME - 1);
      end else begin
         state <= state_n;
         if (change) begin
            presc <= '0;
            timer <= load(state_n);
         end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick && timer != '0)
               timer <= timer - 1'b1;
         end
      end
   end

   // Pedestrian latch, post-walk direction, preempting road
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ped_pending <= 1'b0;
         next_dir    <= 1'b1;
         emerg_dir_q <= 1'b0;
      end else begin
         ped_pending <= ped_req | (ped_pending & ~walk_entry);
         if (walk_entry)
            next_dir <= state == AR1;
         if (change && state_n == EMG)
            emerg_dir_q <= emerg_dir;
      end
   end

   // Lamp decode from state only; greens never overlap
   always_comb begin
      {R1, Y1, G1, R2, Y2, G2, walk} = '0;
      unique case (state)
         GR1:  {G1, R2} = 2'b11;
         YL1:  {Y1, R2} = 2'b11;
         GR2:  {R1, G2} = 2'b11;
         YL2:  {R1, Y2} = 2'b11;
         AR1, AR2: {R1, R2} = 2'b11;
         WALK: {R1, R2, walk} = 3'b111;
         EMG:
            if (emerg_dir_q) {R1, G2} = 2'b11;
            else             {G1, R2} = 2'b11;
      endcase
   end

endmodule

// File: doc/traffic_phase_scheduler.md
TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- CLK_DIV, 4: clock cycles per timing tick; legal range >=1.
- G_TIME, 8: green duration in ticks; legal range >=1.
- Y_TIME, 3: yellow duration in ticks; legal range >=1.
- AR_TIME, 2: all-red clearance in ticks; legal range >=1.
- W_TIME, 5: pedestrian walk duration in ticks; legal range >=1.

REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1: single clock; all state updates on its rising edge.
- reset, in, 1: asynchronous, active-low reset (0 = reset).
- emergency, in, 1: level request for emergency preemption.
- emerg_dir, in, 1: preempting road (0 = road 1, 1 = road 2).
- ped_req, in, 1: pedestrian request pulse or level.
- R1/Y1/G1, out, 1 each: road 1 lamps.
- R2/Y2/G2, out, 1 each: road 2 lamps.
- walk, out, 1: pedestrian walk lamp.
- ped_pending, out, 1: latched pedestrian request.
- phase, out, 3: current state code.

Function
REQ-003 States and phase codes SHALL be GR1=0, YL1=1, AR1=2, GR2=3, YL2=4, AR2=5, WALK=6, EMG=7.
REQ-004 Outputs SHALL be a Moore decode of the state register only:
- GR1: G1, R2.
- YL1: Y1, R2.
- GR2: R1, G2.
- YL2: R1, Y2.
- AR1, AR2, WALK: R1, R2.
- EMG: G1 and R2 if emerg_dir_q=0, else R1 and G2.
- walk SHALL be 1 only in WALK; every unlisted lamp is 0.
REQ-005 Tick generation: a prescaler counts 0..CLK_DIV-1; tick SHALL be asserted when the count equals CLK_DIV-1.
REQ-006 Prescaler and phase timer SHALL both reload on every state change (prescaler to 0, timer to duration-1), so each timed state lasts exactly duration*CLK_DIV cycles.
REQ-007 A timed state SHALL exit on the cycle where tick=1 and timer=0; otherwise the timer decrements on tick.
REQ-008 Normal sequence:
- GR1->YL1->AR1->(WALK if ped_pending)->GR2.
- GR2->YL2->AR2->(WALK if ped_pending)->GR1.
REQ-009 WALK SHALL resume with the green opposite to the all-red it followed, tracked in a 1-bit next-direction register.
REQ-010 ped_req=1 SHALL set ped_pending; entering WALK SHALL clear ped_pending; a set coinciding with the clear SHALL win (pending stays 1).
REQ-011 emergency=1 sampled in GR1/GR2 SHALL force an immediate transition to the matching yellow on the next edge, with timers reloaded.
REQ-012 With emergency=1 at the exit of any AR or WALK, the next state SHALL be EMG instead of a green or WALK.
REQ-013 emerg_dir SHALL be captured into emerg_dir_q on EMG entry and held constant in EMG.
REQ-014 EMG SHALL be untimed and persist while emergency=1.
REQ-015 On emergency=0 in EMG, the next state SHALL be YL1 if emerg_dir_q=0, else YL2; normal sequencing then resumes.
REQ-016 Yellow and all-red SHALL never be truncated by emergency; WALK SHALL complete its full W_TIME.
REQ-017 ped_pending SHALL be retained through EMG and served at the next AR exit with emergency=0.
REQ-018 Conflicting greens (G1 and G2 both 1) SHALL be impossible in every state.

Reset
REQ-019 While reset=0, all of the following SHALL hold regardless of clk:
- state=GR1, phase=0.
- timer=G_TIME-1, prescaler=0.
- ped_pending=0, next-direction=road 2, emerg_dir_q=0.
- Outputs: G1=1, R2=1, all other lamps 0, walk=0.
REQ-020 Reset asserted mid-phase SHALL abort immediately; after release, GR1 lasts a full G_TIME*CLK_DIV cycles.

Verification (defaults)
REQ-021 Release reset, no inputs -> GR1 32 cycles, YL1 12, AR1 8, GR2 32, YL2 12, AR2 8, GR1 again; period 104 cycles.
REQ-022 ped_req pulse during GR1 -> after AR1: WALK for 20 cycles with walk=1, ped_pending=0, then GR2.
REQ-023 emergency=1, emerg_dir=1 at cycle 5 of GR1 -> YL1 next edge (12 cycles), AR1 (8), then EMG with G2=1; drop emergency -> YL2, AR2, GR1.
REQ-024 emergency during YL2 -> YL2 and AR2 complete in full, then EMG; ped_req during EMG -> WALK at first AR exit after release.
REQ-025 reset=0 for 1 cycle in mid-YL2 with no clk edge -> outputs immediately show G1=1, R2=1, phase=0.
REQ-026 Random stimulus on all inputs -> G1&G2 never 1; walk=1 only with R1=R2=1.
